// File: rtl/mem_sram_pkg.sv
// Shared pipeline defines plus the MEM-stage FSM state encodings.
// Latency: n/a (constants, types and decode helpers only).
// Backpressure: n/a.
package mem_sram_pkg;

    localparam logic RstEnable    = 1'b1;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic StallYes     = 1'b1;
    localparam logic StallNo      = 1'b0;

    typedef logic [7:0] AluOpBus;
    typedef logic [4:0] RegAddrBus;

    localparam AluOpBus EXE_OP_NOP   = 8'h00;
    localparam AluOpBus EXE_OP_ADDIU = 8'h09;
    localparam AluOpBus EXE_OP_LW    = 8'h23;
    localparam AluOpBus EXE_OP_LW_SP = 8'h24;
    localparam AluOpBus EXE_OP_SW    = 8'h2B;
    localparam AluOpBus EXE_OP_SW_SP = 8'h2C;

    // MEM stage FSM, 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_WAIT  = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_DONE     = 3'd5
    } mem_state_t;

    function automatic logic op_is_load(input AluOpBus op);
        return (op == EXE_OP_LW) || (op == EXE_OP_LW_SP);
    endfunction

    function automatic logic op_is_store(input AluOpBus op);
        return (op == EXE_OP_SW) || (op == EXE_OP_SW_SP);
    endfunction

endpackage

// File: rtl/mem_sram_if.sv
// External asynchronous SRAM bus between the MEM stage (master) and the pads/SRAM (slave).
// Latency: n/a (wires only); all master-driven strobes are registered in the MEM stage.
// Backpressure: none; timing is owned entirely by the master's strobe sequencing.
// Signals: ram_addr_o, ram_wdata_o, ram_wdata_oe_o, ram_ce_n_o, ram_oe_n_o, ram_we_n_o (master->slave), ram_rdata_i (slave->master).
interface mem_sram_if #(
    parameter int RAM_ADDR_W = 18
);
    logic [RAM_ADDR_W-1:0] ram_addr_o;
    logic [15:0]           ram_wdata_o;
    logic                  ram_wdata_oe_o;
    logic                  ram_ce_n_o;
    logic                  ram_oe_n_o;
    logic                  ram_we_n_o;
    logic [15:0]           ram_rdata_i;

    modport master (
        output ram_addr_o, ram_wdata_o, ram_wdata_oe_o,
        output ram_ce_n_o, ram_oe_n_o, ram_we_n_o,
        input  ram_rdata_i
    );

    modport slave (
        input  ram_addr_o, ram_wdata_o, ram_wdata_oe_o,
        input  ram_ce_n_o, ram_oe_n_o, ram_we_n_o,
        output ram_rdata_i
    );
endinterface

// File: rtl/mem_sram_timer.sv
// Loadable down-counter timing the SRAM read strobe and write pulse.
// Latency: load takes effect on the next edge; o_done is combinational from the count.
// Backpressure: none; i_load has priority over i_dec, count saturates at 0.
// Ports: clk, rst, i_load, i_load_val, i_dec -> o_done (count == 1, i.e. last strobe cycle).
module sram_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_done
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == CNT_W'(1));
endmodule

// File: rtl/mem_sram.sv
// MEM stage: runs LW/LW_SP/SW/SW_SP against an async SRAM, passes other ops through.
// Latency: passthrough 0; load WAIT_CYCLES+1 stall cycles; store WAIT_CYCLES+3 stall cycles.
// Backpressure: stall_req_o holds the upstream latches; forwarding is suppressed while stalled.
// Ports: clk, rst (async, active-high); EX/MEM inputs aluop_i, we_i, waddr_i, wdata_i, mem_addr_i,
//        mem_data_i; sram (master modport, registered strobes); stall_req_o; mem_we_o/mem_waddr_o/mem_wdata_o.
module mem_sram
    import mem_sram_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int RAM_ADDR_W  = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  AluOpBus           aluop_i,
    input  logic              we_i,
    input  RegAddrBus         waddr_i,
    input  logic [15:0]       wdata_i,
    input  logic [15:0]       mem_addr_i,
    input  logic [15:0]       mem_data_i,
    mem_sram_if.master        sram,
    output logic              stall_req_o,
    output logic              mem_we_o,
    output RegAddrBus         mem_waddr_o,
    output logic [15:0]       mem_wdata_o
);
    mem_state_t            r_state;
    mem_state_t            w_state_n;

    logic [RAM_ADDR_W-1:0] r_ram_addr;
    logic [15:0]           r_ram_wdata;
    logic                  r_ram_wdata_oe;
    logic                  r_ram_ce_n;
    logic                  r_ram_oe_n;
    logic                  r_ram_we_n;
    logic [15:0]           r_rdata_q;

    logic                  w_is_load;
    logic                  w_is_store;
    logic                  w_tmr_load;
    logic                  w_tmr_dec;
    logic                  w_tmr_done;
    logic                  w_rst_act;
    logic                  w_stall;
    logic                  w_mem_we;
    RegAddrBus             w_mem_waddr;
    logic [15:0]           w_mem_wdata;

    assign w_is_load  = op_is_load(aluop_i);
    assign w_is_store = op_is_store(aluop_i);
    assign w_rst_act  = (rst == RstEnable);

    sram_timer #(.CNT_W(3)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (3'(WAIT_CYCLES)),
        .i_dec      (w_tmr_dec),
        .o_done     (w_tmr_done)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next state, stall and forwarding outputs. Forwarding is forced off in
    // every stall cycle so ID never picks up stale data for the stalled op.
    always_comb begin
        w_state_n   = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_dec   = 1'b0;
        w_stall     = StallNo;
        w_mem_we    = WriteDisable;
        w_mem_waddr = '0;
        w_mem_wdata = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_is_load) begin
                    w_stall    = StallYes;
                    w_tmr_load = 1'b1;
                    w_state_n  = ST_RD_WAIT;
                end else if (w_is_store) begin
                    w_stall    = StallYes;
                    w_state_n  = ST_WR_SETUP;
                end else begin
                    w_mem_we    = we_i;
                    w_mem_waddr = waddr_i;
                    w_mem_wdata = wdata_i;
                end
            end
            ST_RD_WAIT: begin
                w_stall   = StallYes;
                w_tmr_dec = 1'b1;
                if (w_tmr_done) begin
                    w_state_n = ST_DONE;
                end
            end
            ST_WR_SETUP: begin
                w_stall    = StallYes;
                w_tmr_load = 1'b1;
                w_state_n  = ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
                w_stall   = StallYes;
                w_tmr_dec = 1'b1;
                if (w_tmr_done) begin
                    w_state_n = ST_WR_HOLD;
                end
            end
            ST_WR_HOLD: begin
                w_stall   = StallYes;
                w_state_n = ST_DONE;
            end
            ST_DONE: begin
                // The controller advances EX/MEM on this edge, so the op is
                // still the one that was just executed.
                if (w_is_load) begin
                    w_mem_we    = we_i;
                    w_mem_waddr = waddr_i;
                    w_mem_wdata = r_rdata_q;
                end
                w_state_n = ST_IDLE;
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    // Registered SRAM strobes. Address/data are only loaded from IDLE, so they
    // are stable for a full cycle before we_n falls and until after it rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ram_addr     <= '0;
            r_ram_wdata    <= '0;
            r_ram_wdata_oe <= 1'b0;
            r_ram_ce_n     <= 1'b1;
            r_ram_oe_n     <= 1'b1;
            r_ram_we_n     <= 1'b1;
            r_rdata_q      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_is_load) begin
                        r_ram_addr <= RAM_ADDR_W'(mem_addr_i);
                        r_ram_ce_n <= 1'b0;
                        r_ram_oe_n <= 1'b0;
                    end else if (w_is_store) begin
                        r_ram_addr     <= RAM_ADDR_W'(mem_addr_i);
                        r_ram_wdata    <= mem_data_i;
                        r_ram_wdata_oe <= 1'b1;
                        r_ram_ce_n     <= 1'b0;
                        r_ram_we_n     <= 1'b1;
                    end
                end
                ST_RD_WAIT: begin
                    if (w_tmr_done) begin
                        r_rdata_q  <= sram.ram_rdata_i;
                        r_ram_ce_n <= 1'b1;
                        r_ram_oe_n <= 1'b1;
                    end
                end
                ST_WR_SETUP: begin
                    r_ram_we_n <= 1'b0;
                end
                ST_WR_PULSE: begin
                    if (w_tmr_done) begin
                        r_ram_we_n <= 1'b1;
                    end
                end
                ST_WR_HOLD: begin
                    r_ram_ce_n     <= 1'b1;
                    r_ram_wdata_oe <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign sram.ram_addr_o     = r_ram_addr;
    assign sram.ram_wdata_o    = r_ram_wdata;
    assign sram.ram_wdata_oe_o = r_ram_wdata_oe;
    assign sram.ram_ce_n_o     = r_ram_ce_n;
    assign sram.ram_oe_n_o     = r_ram_oe_n;
    assign sram.ram_we_n_o     = r_ram_we_n;

    // Reset must drop the stall and forwarding immediately, even though the
    // held EX/MEM op would otherwise decode as a memory access in IDLE.
    assign stall_req_o = w_rst_act ? StallNo      : w_stall;
    assign mem_we_o    = w_rst_act ? WriteDisable : w_mem_we;
    assign mem_waddr_o = w_rst_act ? '0           : w_mem_waddr;
    assign mem_wdata_o = w_rst_act ? '0           : w_mem_wdata;
endmodule

// File: doc/mem_sram.md
Name: mem_sram

Overview:
- MEM stage of the 16-bit pipeline. It consumes the EX/MEM latch and executes LW, LW_SP, SW and SW_SP against the external asynchronous SRAM.
- It raises a stall request while an access is in flight.
- It drives the mem_we/mem_waddr/mem_wdata forwarding triple that ID consumes, and that the MEM/WB latch also captures.
- Non-memory ops pass straight through with zero latency.

Parameters:
- WAIT_CYCLES, 1, number of cycles the SRAM read strobe or write pulse is held; legal range 1..7.
- RAM_ADDR_W, 18, external SRAM address width; the 16-bit address is zero-extended.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high (`RstEnable = 1)
- aluop_i  in  AluOpBus  op from EX; EXE_OP_LW / EXE_OP_LW_SP = load, EXE_OP_SW / EXE_OP_SW_SP = store, anything else = passthrough
- we_i  in  1  register write enable from EX
- waddr_i  in  RegAddrBus  destination register
- wdata_i  in  16  ALU result (passthrough data)
- mem_addr_i  in  16  effective address
- mem_data_i  in  16  store data
- ram_rdata_i  in  16  SRAM read data
- ram_addr_o  out  RAM_ADDR_W  SRAM address (registered)
- ram_wdata_o  out  16  SRAM write data (registered)
- ram_wdata_oe_o  out  1  pad output enable for the data bus (registered)
- ram_ce_n_o  out  1  chip enable, active-low (registered)
- ram_oe_n_o  out  1  output enable, active-low (registered)
- ram_we_n_o  out  1  write enable, active-low (registered)
- stall_req_o  out  1  to the pipeline controller; 1 = hold PC, IF/ID, ID/EX and EX/MEM
- mem_we_o  out  1  forwarding / write-back enable
- mem_waddr_o  out  RegAddrBus  forwarding / write-back address
- mem_wdata_o  out  16  forwarding / write-back data

Behaviour:
- Reset (asynchronous, any state):
  - state goes to IDLE; wait counter 0; rdata_q 0.
  - ram_ce_n_o, ram_oe_n_o, ram_we_n_o = 1; ram_addr_o, ram_wdata_o = 0; ram_wdata_oe_o = 0.
  - stall_req_o = 0; mem_we_o = 0; mem_waddr_o = 0; mem_wdata_o = 0.
  - A reset in the middle of an access aborts it, with no further strobe edges.
- FSM states: IDLE, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- The EX/MEM inputs are held stable by the controller for as long as stall_req_o = 1.
- IDLE:
  - Passthrough op: mem_we_o/mem_waddr_o/mem_wdata_o = we_i/waddr_i/wdata_i (combinational); stall_req_o = 0; state stays IDLE.
  - Load: stall_req_o = 1 and mem_we_o = 0. On the clock edge: ram_addr_o = zero-extended mem_addr_i; ce_n = 0; oe_n = 0; counter = WAIT_CYCLES; state goes to RD_WAIT.
  - Store: stall_req_o = 1 and mem_we_o = 0. On the clock edge: ram_addr_o set; ram_wdata_o = mem_data_i; wdata_oe = 1; ce_n = 0; we_n = 1; state goes to WR_SETUP.
- RD_WAIT:
  - stall = 1 and mem_we_o = 0.
  - Counter decrements each cycle.
  - On the edge where counter == 1: rdata_q = ram_rdata_i; ce_n = 1; oe_n = 1; state goes to DONE.
- WR_SETUP: stall = 1. On the next edge: we_n = 0, counter = WAIT_CYCLES, state goes to WR_PULSE.
- WR_PULSE:
  - stall = 1; the counter decrements.
  - On the edge where counter == 1: we_n = 1; state goes to WR_HOLD. Address and data stay unchanged.
- WR_HOLD: stall = 1. On the next edge: ce_n = 1, wdata_oe = 0, state goes to DONE.
- DONE:
  - stall_req_o = 0.
  - Load: mem_we_o = we_i, mem_waddr_o = waddr_i, mem_wdata_o = rdata_q.
  - Store: mem_we_o = 0, waddr = 0, wdata = 0.
  - On the next edge the state goes to IDLE unconditionally. The controller advances the latch on this same edge, so the next instruction is seen in IDLE.
- Latency:
  - Load: WAIT_CYCLES+1 stall cycles, with the result forwarded in the DONE cycle.
  - Store: WAIT_CYCLES+3 stall cycles.
- Write strobe safety: we_n never falls in the same cycle that address or data change, and never overlaps oe_n = 0.
- Back-to-back accesses: a load immediately following a DONE starts a fresh IDLE-to-RD_WAIT sequence with no overlap.
- While stall_req_o = 1, mem_we_o = 0, so ID never forwards stale data for the stalled instruction.
- An address of 0xFFFF maps to 0x0FFFF; there is no wrap or carry into the upper bits.

Decomposition:
- Shared defines file (existing): EXE_OP_LW / LW_SP / SW / SW_SP, AluOpBus, RegAddrBus, RstEnable, WriteEnable, StallYes/StallNo.
- New constants for the FSM state encodings (3 bits) go in the same file.
- One sub-module, sram_timer: a loadable down-counter with a done flag, shared by RD_WAIT and WR_PULSE.

Test Plan:
- Reset mid-write: assert rst during WR_PULSE -> ram_we_n_o = 1, ram_ce_n_o = 1 and stall_req_o = 0 immediately (asynchronously); state is IDLE after release.
- Passthrough: aluop = EXE_OP_ADDIU, we = 1, waddr = 3, wdata = 0x1234 -> same cycle mem_we_o = 1, mem_waddr_o = 3, mem_wdata_o = 0x1234; stall_req_o = 0; SRAM strobes stay high.
- Load, WAIT_CYCLES = 1: LW with addr 0x0040, SRAM model returns 0xBEEF, waddr = 5 -> stall high for 2 cycles; ram_oe_n_o low for 1 cycle; DONE cycle gives mem_we_o = 1, waddr 5, wdata 0xBEEF.
- Store, WAIT_CYCLES = 2: SW with addr 0x8001, data 0xA5A5 -> ram_addr_o = 0x08001; we_n low exactly 2 cycles; data valid from one cycle before we_n falls to one cycle after it rises; stall high for 5 cycles; mem_we_o = 0 throughout.
- Back-to-back: SW to 0x0010 with data 0x0007, then LW from 0x0010 -> load returns 0x0007; the two accesses do not overlap; there is exactly one DONE cycle each.
- Forward suppression: during RD_WAIT, with waddr_i equal to a register that ID is reading -> mem_we_o = 0 in every stall cycle.
